// File: rtl/bus_rr_arbiter.sv
// Two-CPU round-robin arbiter/sequencer for the shared dmem port and coherence bus.
// One owner at a time; outputs are registered from the next-state decode.
module bus_rr_arbiter #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [1:0]        op_0,
  input  logic [1:0]        op_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              mem_rdy,
  output logic              grant_0,
  output logic              grant_1,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              timeout_err,
  output logic              last_grant
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COH} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                lg_d;
  logic                win;
  logic [1:0]          sel_op;
  logic                re_d, we_d, tmo_d, busy_d;

  // last_grant doubles as the owner of the transaction in flight.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = mem_addr;
    lg_d    = last_grant;
    win     = 1'b0;
    sel_op  = 2'b00;
    re_d    = 1'b0;
    we_d    = 1'b0;
    tmo_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_0 || req_1) begin
          win    = (req_0 && req_1) ? !last_grant : req_1;
          sel_op = win ? op_1 : op_0;
          lg_d   = win;
          addr_d = win ? addr_1 : addr_0;
          cnt_d  = '0;
          if (sel_op[1]) begin
            state_d = COH;
          end else begin
            state_d = ISSUE;
            re_d    = (sel_op[0] == 1'b0);
            we_d    = (sel_op[0] == 1'b1);
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // mem_rdy takes precedence over an expiring timeout in the same cycle.
        if (mem_rdy) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      COH: begin
        if (cnt == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      grant_0     <= 1'b0;
      grant_1     <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      grant_0     <= busy_d && !lg_d;
      grant_1     <= busy_d && lg_d;
      mem_re      <= re_d;
      mem_we      <= we_d;
      mem_addr    <= addr_d;
      busy        <= busy_d;
      timeout_err <= tmo_d;
      last_grant  <= lg_d;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: per-cycle assertions plus a strobe scoreboard.
module tb_bus_rr_arbiter;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_0, req_1, mem_rdy;
  logic [1:0]    op_0, op_1;
  logic [AW-1:0] addr_0, addr_1;
  logic          grant_0, grant_1, mem_re, mem_we, busy, timeout_err, last_grant;
  logic [AW-1:0] mem_addr;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          g0;
    logic          g1;
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
  } strobe_t;

  strobe_t sb_q[$];

  bus_rr_arbiter #(.ADDR_W(AW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1), .op_0(op_0), .op_1(op_1),
    .addr_0(addr_0), .addr_1(addr_1), .mem_rdy(mem_rdy),
    .grant_0(grant_0), .grant_1(grant_1), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .busy(busy), .timeout_err(timeout_err),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic push(input logic owner, input logic we, input logic [AW-1:0] a);
    strobe_t s;
    s.g0 = !owner; s.g1 = owner; s.re = !we; s.we = we; s.addr = a;
    sb_q.push_back(s);
  endtask

  // Strobe scoreboard and grant exclusivity, sampled mid-cycle.
  always @(negedge clk) begin
    strobe_t got, want;
    if (!rst) begin
      n_assert++;
      assert (!(grant_0 && grant_1)) else begin
        n_fail++;
        $error("FAIL grant_excl: observed g0=%b g1=%b expected not both", grant_0, grant_1);
      end
      if (mem_re || mem_we) begin
        n_assert++;
        assert (sb_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed strobe re=%b we=%b expected none", mem_re, mem_we);
        end
        if (sb_q.size() != 0) begin
          want = sb_q.pop_front();
          got  = {grant_0, grant_1, mem_re, mem_we, mem_addr};
          n_assert++;
          assert (got === want) else begin
            n_fail++;
            $error("FAIL sb_strobe: observed %h expected %h", got, want);
          end
        end
      end
    end
  end

  initial begin
    logic o;
    logic [AW-1:0] a;
    rst = 1'b1; req_0 = 0; req_1 = 0; op_0 = 0; op_1 = 0;
    addr_0 = '0; addr_1 = '0; mem_rdy = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_grant0", grant_0, 0); chk("rst_grant1", grant_1, 0);
    chk("rst_re", mem_re, 0); chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0); chk("rst_busy", busy, 0);
    chk("rst_tmo", timeout_err, 0); chk("rst_lg", last_grant, 1);

    // Single read from CPU0, mem_rdy three cycles after the strobe.
    req_0 = 1; op_0 = 2'b00; addr_0 = 13'h0A5;
    push(1'b0, 1'b0, 13'h0A5);
    tick();
    chk("t1_issue_g0", grant_0, 1); chk("t1_issue_re", mem_re, 1);
    chk("t1_issue_addr", mem_addr, 13'h0A5); chk("t1_issue_busy", busy, 1);
    req_0 = 0; op_0 = 2'b01; addr_0 = 13'h1FF;
    tick();
    chk("t1_w1_g0", grant_0, 1); chk("t1_w1_re", mem_re, 0);
    chk("t1_w1_addr", mem_addr, 13'h0A5);
    tick(); tick();
    mem_rdy = 1;
    tick();
    mem_rdy = 0;
    chk("t1_done_g0", grant_0, 0); chk("t1_done_busy", busy, 0);
    chk("t1_done_lg", last_grant, 0);

    // Contended writes alternate owners with one IDLE cycle between.
    req_0 = 1; req_1 = 1; op_0 = 2'b01; op_1 = 2'b01;
    o = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_0 = 13'(32'h100 + i);
      addr_1 = 13'(32'h1F0 + i);
      a = o ? addr_1 : addr_0;
      push(o, 1'b1, a);
      tick();
      chk("t2_g0", grant_0, !o); chk("t2_g1", grant_1, o);
      chk("t2_we", mem_we, 1); chk("t2_addr", mem_addr, a);
      tick();
      chk("t2_w1_we", mem_we, 0); chk("t2_w1_busy", busy, 1);
      mem_rdy = 1;
      tick();
      mem_rdy = 0;
      chk("t2_idle_busy", busy, 0); chk("t2_idle_g", grant_0 | grant_1, 0);
      chk("t2_lg", last_grant, o);
      o = !o;
    end
    req_0 = 0; req_1 = 0;
    tick();

    // Coherence-only: grant for exactly two cycles, no strobes (op 11 behaves as 10).
    req_1 = 1; op_1 = 2'b10; addr_1 = 13'h055;
    tick();
    req_1 = 0;
    chk("t3_c1_g1", grant_1, 1); chk("t3_c1_busy", busy, 1); chk("t3_c1_addr", mem_addr, 13'h055);
    chk("t3_c1_strb", {mem_re, mem_we}, 0);
    tick();
    chk("t3_c2_g1", grant_1, 1); chk("t3_c2_busy", busy, 1);
    chk("t3_c2_strb", {mem_re, mem_we}, 0);
    tick();
    chk("t3_end_g1", grant_1, 0); chk("t3_end_busy", busy, 0);
    req_0 = 1; op_0 = 2'b11; addr_0 = 13'h077;
    tick();
    req_0 = 0;
    chk("t3b_c1_g0", grant_0, 1); chk("t3b_c1_strb", {mem_re, mem_we}, 0);
    tick();
    chk("t3b_c2_g0", grant_0, 1);
    tick();
    chk("t3b_end_g0", grant_0, 0); chk("t3b_lg", last_grant, 0);

    // Read that never completes: abort after four WAIT cycles.
    req_0 = 1; op_0 = 2'b00; addr_0 = 13'h123;
    push(1'b0, 1'b0, 13'h123);
    tick();
    req_0 = 0;
    chk("t4_issue_g0", grant_0, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_wait_g0", grant_0, 1); chk("t4_wait_tmo", timeout_err, 0);
    end
    tick();
    chk("t4_abort_g0", grant_0, 0); chk("t4_abort_busy", busy, 0);
    chk("t4_abort_tmo", timeout_err, 1);
    tick();
    chk("t4_tmo_pulse", timeout_err, 0);
    req_1 = 1; op_1 = 2'b01; addr_1 = 13'h0AA;
    push(1'b1, 1'b1, 13'h0AA);
    tick();
    req_1 = 0;
    chk("t4_next_g1", grant_1, 1); chk("t4_next_we", mem_we, 1);
    tick();
    mem_rdy = 1;
    tick();
    mem_rdy = 0;
    chk("t4_next_done", busy, 0); chk("t4_next_tmo", timeout_err, 0);

    // mem_rdy in the final WAIT cycle beats the timeout.
    req_0 = 1; op_0 = 2'b00; addr_0 = 13'h0F0;
    push(1'b0, 1'b0, 13'h0F0);
    tick();
    req_0 = 0;
    tick(); tick(); tick(); tick();
    chk("t5_w4_g0", grant_0, 1);
    mem_rdy = 1;
    tick();
    mem_rdy = 0;
    chk("t5_done_g0", grant_0, 0); chk("t5_done_tmo", timeout_err, 0);
    tick();
    chk("t5_after_tmo", timeout_err, 0);

    // Asynchronous reset in WAIT, then contention goes to CPU0.
    req_1 = 1; op_1 = 2'b00; addr_1 = 13'h1AB;
    push(1'b1, 1'b0, 13'h1AB);
    tick();
    req_1 = 0;
    tick();
    chk("t6_wait_g1", grant_1, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_g1", grant_1, 0); chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", mem_addr, 0); chk("t6_rst_lg", last_grant, 1);
    chk("t6_rst_tmo", timeout_err, 0);
    tick();
    rst = 1'b0;
    req_0 = 1; req_1 = 1; op_0 = 2'b01; op_1 = 2'b01;
    addr_0 = 13'h0C3; addr_1 = 13'h13C;
    push(1'b0, 1'b1, 13'h0C3);
    tick();
    req_0 = 0; req_1 = 0;
    chk("t6_first_g0", grant_0, 1); chk("t6_first_g1", grant_1, 0);
    tick();
    mem_rdy = 1;
    tick();
    mem_rdy = 0;
    chk("t6_done_busy", busy, 0); chk("t6_done_tmo", timeout_err, 0);
    tick();

    chk("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
